wavetable_arbiter: RTL and testbench
====================================

Name: wavetable_arbiter

Overview:
- Parametrised shared-wavetable access block: NUM_REQ voice requestors share one synchronous single-port wavetable ROM through a round-robin arbiter with a valid/ready handshake.
- Each accepted read returns through a per-requestor holding register with a one-cycle response strobe.
- Sits between the voice generators and the wavetable ROM instance, which is external to this block.
- Replaces fixed-priority, no-backpressure sharing with fair arbitration, backpressure, a configurable ROM latency and contention/protocol status.

Parameters:
- NUM_REQ, 32, number of requestors (≥2).
- ADDR_W, 10, wavetable address width.
- DATA_W, 18, wavetable sample width.
- ROM_LATENCY, 1, ROM cycles from rom_en/rom_addr to valid rom_data (1..4).
- CNT_W, 16, width of the contention counter.

Ports:
- clk, in, 1, system clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- req_valid, in, NUM_REQ, per-requestor read request.
- req_addr, in, NUM_REQ*ADDR_W, packed addresses; requestor i uses slice [i*ADDR_W +: ADDR_W].
- req_ready, out, NUM_REQ, one-hot grant (combinational).
- rsp_valid, out, NUM_REQ, one-cycle strobe when requestor i's data register is updated.
- rsp_data, out, NUM_REQ*DATA_W, packed per-requestor holding registers.
- rom_en, out, 1, ROM enable.
- rom_addr, out, ADDR_W, ROM address.
- rom_data, in, DATA_W, ROM read data.
- cnt_clr, in, 1, synchronous clear of contention_cnt.
- contention_cnt, out, CNT_W, saturating count of cycles with ≥2 req_valid.
- protocol_err, out, 1, sticky protocol violation flag.

Behaviour:
- Reset (async, rst_n=0): rsp_data all 0, rsp_valid 0, pipeline tags invalid, RR pointer 0, contention_cnt 0, protocol_err 0.
- During reset, req_ready is forced to 0 and rom_en is 0.
- Arbitration:
  - Grant g is the first i with req_valid[i]=1, searching from ptr upward with wrap modulo NUM_REQ.
  - req_ready = onehot(g); all zeros if no request is valid.
  - Handshake occurs when req_valid[g] & req_ready[g] in cycle T.
  - On each handshake, ptr <= (g+1) mod NUM_REQ. With no grant, ptr holds.
  - At most one grant per cycle; sustained throughput is 1 read per cycle.
- ROM drive (combinational): rom_addr = req_addr slice of g, or 0 if no grant. rom_en = any grant OR any pipeline tag valid.
- Tag pipeline:
  - ROM_LATENCY stages, each holding {valid, index}. The stage-0 input is {grant_any, g}.
  - When the last stage is valid with index k: rsp_data[k] <= rom_data and rsp_valid[k] <= 1 on that edge. All other rsp_valid bits are 0.
- Latency: request accepted in cycle T → rsp_valid[i] and the new rsp_data slice are visible in cycle T+ROM_LATENCY+1. For example, ROM_LATENCY=1 gives T+2.
- rsp_data slices hold their value until the next response to the same requestor.
- Requestor protocol:
  - req_valid must stay high, with a stable address, until accepted.
  - If req_valid[i] was 1 and req_ready[i] was 0 in cycle T-1, and req_valid[i] is 0 in T, then protocol_err <= 1. It is sticky until reset.
  - Address stability is not checked by hardware.
- A requestor may issue back-to-back requests. Its responses return in issue order, because the pipeline is in-order.
- Contention:
  - contention_cnt increments each cycle in which popcount(req_valid) ≥ 2 and saturates at 2^CNT_W-1.
  - cnt_clr has priority over increment; the value is 0 on the next cycle.
- Reset mid-operation: in-flight tags are discarded and no rsp_valid is produced for them. Post-reset arbitration starts at ptr=0.
- Boundary cases:
  - Wrap: with ptr=NUM_REQ-1, the search proceeds to index 0 next.
  - A single requestor continuously valid is granted every cycle.

Decomposition:
- Package wavetable_pkg holds:
  - Default ADDR_W and DATA_W constants.
  - A clog2 function for the index width.
  - The tag record layout {valid, index}.
- Sub-module rr_arbiter (NUM_REQ): inputs req and advance; outputs onehot grant and binary index; contains the pointer register.
- Tag pipeline, counters and output registers stay in wavetable_arbiter.

Test Plan:
- Single request: NUM_REQ=32, ROM_LATENCY=1, req_valid[5]=1 at T with addr 0x123, ROM model returning addr^0x3FFFF → req_ready[5]=1 at T, rom_addr=0x123, rsp_valid[5]=1 at T+2 only, rsp_data[5]=0x3FEDC.
- Fairness: requestors 0, 3 and 31 held valid continuously → grants rotate 0,3,31,0,3,31; no requestor waits more than 2 cycles; contention_cnt increments every cycle.
- Wrap and latency: ROM_LATENCY=3, ptr at 31, req 31 then req 0 back-to-back → grants 31 then 0, with rsp_valid at T+4 and T+5 in order.
- Back-to-back same requestor: req 7 valid 4 cycles with addrs 0,1,2,3 → 4 rsp_valid[7] strobes on consecutive cycles with data matching the addresses in order.
- Protocol error: req 2 valid while req 1 is granted, then req 2 dropped before its grant → protocol_err=1 next cycle and it stays high; cnt_clr pulse → contention_cnt=0.
- Reset mid-flight: rst_n pulled low 1 cycle after acceptance → no rsp_valid afterwards, rsp_data all 0, and the next grant comes from index 0 upward.

Source files
------------

// File: rtl/wavetable_pkg.sv
// wavetable_pkg
// Shared definitions for the wavetable arbiter slice.
//   DEF_ADDR_W / DEF_DATA_W : default wavetable address / sample widths
//   TAG_IDX_W               : index field width of an in-flight read tag
//   tag_t                   : {valid, index} record carried alongside each ROM read
//   clog2()                 : ceiling log2, used to size requestor indices
package wavetable_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 18;

  // Tag index field is fixed-width so the record layout is shared by every
  // instance; it covers up to 256 requestors.
  localparam int TAG_IDX_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] index;
  } tag_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/wavetable_arbiter_rr.sv
// rr_arbiter
// Round-robin grant over NUM_REQ requests. The search starts at the pointer
// and wraps; the pointer moves one past the winner whenever advance is high.
//   clk, rst_n : clock, asynchronous active-low reset (pointer returns to 0)
//   req        : request vector
//   advance    : a handshake happened this cycle, move the pointer
//   grant      : one-hot grant, all zeros when no request
//   grant_idx  : binary index of the granted requestor (0 when none)
module rr_arbiter
  import wavetable_pkg::*;
#(
  parameter  int NUM_REQ = 32,
  localparam int IDX_W   = clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  // Linear scan from the pointer, first hit wins.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand_idx = IDX_W'((int'(ptr_reg) + off) % NUM_REQ);
      if (!found && req[cand_idx]) begin
        found     = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (found) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (advance) begin
      ptr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_reg <= '0;
    else        ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/wavetable_arbiter.sv
// wavetable_arbiter
// Shares one synchronous single-port wavetable ROM among NUM_REQ voices.
// One round-robin grant per cycle; each accepted read carries a tag through a
// ROM_LATENCY-deep pipeline and lands in the requestor's holding register.
//   clk, rst_n     : clock, asynchronous active-low reset
//   req_valid      : per-requestor read request
//   req_addr       : packed addresses, requestor i at [i*ADDR_W +: ADDR_W]
//   req_ready      : one-hot grant (combinational, 0 during reset)
//   rsp_valid      : one-cycle strobe when requestor i's register updates
//   rsp_data       : packed per-requestor holding registers
//   rom_en/addr    : ROM drive (combinational)
//   rom_data       : ROM read data, ROM_LATENCY cycles after rom_en/rom_addr
//   cnt_clr        : synchronous clear of contention_cnt
//   contention_cnt : saturating count of cycles with two or more requests
//   protocol_err   : sticky, set when a waiting request is withdrawn
module wavetable_arbiter
  import wavetable_pkg::*;
#(
  parameter  int NUM_REQ     = 32,
  parameter  int ADDR_W      = DEF_ADDR_W,
  parameter  int DATA_W      = DEF_DATA_W,
  parameter  int ROM_LATENCY = 1,
  parameter  int CNT_W       = 16,
  localparam int IDX_W       = clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0] rsp_data,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  input  logic                      cnt_clr,
  output logic [CNT_W-1:0]          contention_cnt,
  output logic                      protocol_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_REQ-1:0]     grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_any;
  tag_t                   tag_in;
  tag_t                   tag_reg [ROM_LATENCY];
  tag_t                   last_tag;
  logic [ROM_LATENCY-1:0] tag_valid_vec;
  logic [NUM_REQ-1:0]     pend_reg;
  logic                   multi_req;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   perr_reg;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .advance   (grant_any),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grant is qualified by rst_n so nothing is accepted while held in reset.
  assign req_ready = rst_n ? grant : '0;
  assign grant_any = |req_ready;
  assign rom_addr  = grant_any ? req_addr[grant_idx*ADDR_W +: ADDR_W] : '0;

  // ---------------- tag pipeline, mirrors the ROM latency ----------------
  assign tag_in = '{valid: grant_any, index: TAG_IDX_W'(grant_idx)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < ROM_LATENCY; s++) tag_reg[s] <= '0;
    end else begin
      tag_reg[0] <= tag_in;
      for (int s = 1; s < ROM_LATENCY; s++) tag_reg[s] <= tag_reg[s-1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ROM_LATENCY; gi++) begin : g_tag_valid
      assign tag_valid_vec[gi] = tag_reg[gi].valid;
    end
  endgenerate

  // ROM stays enabled while any read is still in flight so its output
  // pipeline keeps moving.
  assign rom_en   = grant_any | (|tag_valid_vec);
  assign last_tag = tag_reg[ROM_LATENCY-1];

  // ---------------- per-requestor holding registers ----------------
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
      logic              hit;
      logic              valid_reg;
      logic [DATA_W-1:0] data_reg;

      assign hit = last_tag.valid && (last_tag.index == TAG_IDX_W'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else begin
          valid_reg <= hit;
          if (hit) data_reg <= rom_data;
        end
      end

      assign rsp_valid[gi]                  = valid_reg;
      assign rsp_data[gi*DATA_W +: DATA_W] = data_reg;
    end
  endgenerate

  // ---------------- contention counter and protocol check ----------------
  // x & (x-1) clears the lowest set bit: non-zero iff two or more are set.
  assign multi_req = |(req_valid & (req_valid - 1'b1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      pend_reg <= '0;
      perr_reg <= 1'b0;
    end else begin
      if (cnt_clr)                             cnt_reg <= '0;
      else if (multi_req && cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + 1'b1;
      // Requests left waiting this cycle must still be present next cycle.
      pend_reg <= req_valid & ~req_ready;
      if (|(pend_reg & ~req_valid)) perr_reg <= 1'b1;
    end
  end

  assign contention_cnt = cnt_reg;
  assign protocol_err   = perr_reg;

endmodule

// File: tb/tb_wavetable_arbiter.sv
// tb_wavetable_arbiter
// Two instances share the same stimulus: u_dut1 with ROM_LATENCY=1 and
// u_dut3 with ROM_LATENCY=3. Each has its own ROM model returning
// addr ^ 0x3FFFF. A vector table covers arbitration, wrap and contention;
// hand-written sequences cover response timing, protocol error, counter
// clear and reset during flight.
module tb_wavetable_arbiter;

  localparam int N  = 32;
  localparam int AW = 10;
  localparam int DW = 18;
  localparam int CW = 16;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic            cnt_clr;

  logic [N-1:0]    u1_ready, u3_ready, u1_rsp_valid, u3_rsp_valid;
  logic [N*DW-1:0] u1_rsp_data, u3_rsp_data;
  logic            u1_rom_en, u3_rom_en;
  logic [AW-1:0]   u1_rom_addr, u3_rom_addr;
  logic [DW-1:0]   u1_rom_data, u3_rom_data;
  logic [CW-1:0]   u1_cnt, u3_cnt;
  logic            u1_perr, u3_perr;

  int n_vec  = 0;
  int n_fail = 0;

  wavetable_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(1), .CNT_W(CW)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(u1_ready), .rsp_valid(u1_rsp_valid), .rsp_data(u1_rsp_data),
    .rom_en(u1_rom_en), .rom_addr(u1_rom_addr), .rom_data(u1_rom_data),
    .cnt_clr(cnt_clr), .contention_cnt(u1_cnt), .protocol_err(u1_perr)
  );

  wavetable_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(3), .CNT_W(CW)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(u3_ready), .rsp_valid(u3_rsp_valid), .rsp_data(u3_rsp_data),
    .rom_en(u3_rom_en), .rom_addr(u3_rom_addr), .rom_data(u3_rom_data),
    .cnt_clr(cnt_clr), .contention_cnt(u3_cnt), .protocol_err(u3_perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM models: enabled pipelines of the requested depth
  logic [DW-1:0] rom3_pipe [3];
  always @(posedge clk) if (u1_rom_en) u1_rom_data <= {8'h00, u1_rom_addr} ^ 18'h3FFFF;
  always @(posedge clk) begin
    if (u3_rom_en) begin
      rom3_pipe[0] <= {8'h00, u3_rom_addr} ^ 18'h3FFFF;
      rom3_pipe[1] <= rom3_pipe[0];
      rom3_pipe[2] <= rom3_pipe[1];
    end
  end
  assign u3_rom_data = rom3_pipe[2];

  function automatic logic [AW-1:0] addr_of(input int i);
    return AW'((i * 37 + 5) % 1024);
  endfunction

  function automatic logic [DW-1:0] rom_of(input logic [AW-1:0] a);
    return {8'h00, a} ^ 18'h3FFFF;
  endfunction

  function automatic logic [DW-1:0] d1(input int i);
    return u1_rsp_data[i*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] d3(input int i);
    return u3_rsp_data[i*DW +: DW];
  endfunction

  function automatic logic [N-1:0] bit_of(input int i);
    logic [N-1:0] one;
    one = 1;
    return (i < 0) ? '0 : (one << i);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pattern();
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = addr_of(i);
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    cnt_clr   = 1'b0;
    req_valid = '1;
    #1;
    chk("rst_ready1", u1_ready, 0);
    chk("rst_ready3", u3_ready, 0);
    chk("rst_rom_en1", u1_rom_en, 0);
    chk("rst_rom_en3", u3_rom_en, 0);
    tick();
    tick();
    chk("rst_rsp_valid", u1_rsp_valid | u3_rsp_valid, 0);
    chk("rst_rsp_data", (|u1_rsp_data) | (|u3_rsp_data), 0);
    chk("rst_cnt", u1_cnt, 0);
    chk("rst_perr", u1_perr | u3_perr, 0);
    req_valid = '0;
    rst_n     = 1'b1;
    $display("reset applied");
  endtask

  typedef struct {
    logic [N-1:0] rv;
    int           g;
    int           cnt;
    logic         en;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // grant expected from the pointer left by the previous vector
    tbl[0]  = '{32'h0000_0000, -1, 0, 1'b0};
    tbl[1]  = '{32'h0000_0020,  5, 0, 1'b1};
    tbl[2]  = '{32'h8000_0009, 31, 1, 1'b1};
    tbl[3]  = '{32'h8000_0009,  0, 2, 1'b1};
    tbl[4]  = '{32'h8000_0009,  3, 3, 1'b1};
    tbl[5]  = '{32'h8000_0009, 31, 4, 1'b1};
    tbl[6]  = '{32'h0000_0009,  0, 5, 1'b1};
    tbl[7]  = '{32'h0000_0008,  3, 5, 1'b1};
    tbl[8]  = '{32'h0000_0006,  1, 6, 1'b1};
    tbl[9]  = '{32'h0000_0005,  2, 7, 1'b1};
    tbl[10] = '{32'h0000_0001,  0, 7, 1'b1};
    tbl[11] = '{32'h0000_0000, -1, 7, 1'b1};
    tbl[12] = '{32'hC000_0000, 30, 8, 1'b1};
    tbl[13] = '{32'h8000_0001, 31, 9, 1'b1};
    tbl[14] = '{32'h0000_0001,  0, 9, 1'b1};

    req_valid = '0;
    req_addr  = '0;
    cnt_clr   = 1'b0;
    rst_n     = 1'b0;
    tick();

    // ---------------- table: arbitration, fairness, wrap, contention ----
    reset_dut();
    set_pattern();
    for (int v = 0; v < 15; v++) begin
      req_valid = tbl[v].rv;
      #1;
      chk($sformatf("v%0d_ready1", v), u1_ready, bit_of(tbl[v].g));
      chk($sformatf("v%0d_ready3", v), u3_ready, bit_of(tbl[v].g));
      chk($sformatf("v%0d_rom_addr", v), u1_rom_addr, (tbl[v].g < 0) ? '0 : addr_of(tbl[v].g));
      chk($sformatf("v%0d_rom_en", v), u1_rom_en, tbl[v].en);
      tick();
      chk($sformatf("v%0d_cnt", v), u1_cnt, tbl[v].cnt);
      chk($sformatf("v%0d_perr", v), u1_perr, 0);
      $display("vec %0d: req_valid=%h ready=%h cnt=%0d", v, tbl[v].rv, u1_ready, u1_cnt);
    end
    req_valid = '0;

    // ---------------- single request, response timing ----------------
    reset_dut();
    req_addr[5*AW +: AW] = 10'h123;
    req_valid = bit_of(5);                                   // cycle T
    #1;
    chk("single_ready", u1_ready, bit_of(5));
    chk("single_rom_addr", u1_rom_addr, 10'h123);
    chk("single_rom_en", u1_rom_en, 1);
    tick();                                                  // T+1
    chk("single_t1_rsp", u1_rsp_valid, 0);
    req_valid = '0;
    tick();                                                  // T+2
    chk("single_t2_rsp", u1_rsp_valid, bit_of(5));
    chk("single_t2_data", d1(5), 18'h3FEDC);
    chk("single_t2_rsp3", u3_rsp_valid, 0);
    tick();                                                  // T+3
    chk("single_t3_rsp", u1_rsp_valid, 0);
    chk("single_t3_hold", d1(5), 18'h3FEDC);
    tick();                                                  // T+4
    chk("single_t4_rsp3", u3_rsp_valid, bit_of(5));
    chk("single_t4_data3", d3(5), 18'h3FEDC);
    $display("single request: rsp_data[5]=%h", d1(5));

    // ---------------- wrap and latency ----------------
    reset_dut();
    set_pattern();
    req_valid = bit_of(30);                                  // T-1, ptr -> 31
    tick();
    req_valid = 32'h8000_0001;                               // T
    #1;
    chk("wrap_g31_1", u1_ready, bit_of(31));
    chk("wrap_g31_3", u3_ready, bit_of(31));
    tick();                                                  // T+1
    req_valid = bit_of(0);
    #1;
    chk("wrap_g0_3", u3_ready, bit_of(0));
    tick();                                                  // T+2
    req_valid = '0;
    chk("wrap_t2_rsp1", u1_rsp_valid, bit_of(31));
    chk("wrap_t2_data1", d1(31), rom_of(addr_of(31)));
    tick();                                                  // T+3
    chk("wrap_t3_rsp1", u1_rsp_valid, bit_of(0));
    chk("wrap_t3_data1", d1(0), rom_of(addr_of(0)));
    chk("wrap_t3_rsp3", u3_rsp_valid, bit_of(30));
    tick();                                                  // T+4
    chk("wrap_t4_rsp3", u3_rsp_valid, bit_of(31));
    chk("wrap_t4_data3", d3(31), rom_of(addr_of(31)));
    tick();                                                  // T+5
    chk("wrap_t5_rsp3", u3_rsp_valid, bit_of(0));
    chk("wrap_t5_data3", d3(0), rom_of(addr_of(0)));
    tick();                                                  // T+6
    chk("wrap_t6_rsp3", u3_rsp_valid, 0);
    $display("wrap/latency: grants 31,0 responses in order");

    // ---------------- back-to-back same requestor ----------------
    reset_dut();
    for (int k = 0; k < 6; k++) begin                        // cycle T+k
      if (k >= 2) begin
        chk($sformatf("b2b_rsp%0d", k - 2), u1_rsp_valid, bit_of(7));
        chk($sformatf("b2b_data%0d", k - 2), d1(7), rom_of(AW'(k - 2)));
      end
      if (k < 4) begin
        req_valid = bit_of(7);
        req_addr[7*AW +: AW] = AW'(k);
        #1;
        chk($sformatf("b2b_ready%0d", k), u1_ready, bit_of(7));
      end else begin
        req_valid = '0;
      end
      tick();
    end
    chk("b2b_after", u1_rsp_valid, 0);
    $display("back-to-back: 4 responses to requestor 7");

    // ---------------- protocol error and counter clear ----------------
    reset_dut();
    req_valid = 32'h0000_0006;                               // T
    #1;
    chk("perr_ready", u1_ready, bit_of(1));
    tick();                                                  // T+1
    chk("perr_before", u1_perr, 0);
    chk("perr_cnt1", u1_cnt, 1);
    req_valid = '0;                                          // 2 withdrawn
    tick();                                                  // T+2
    chk("perr_set", u1_perr, 1);
    tick();                                                  // T+3
    chk("perr_sticky", u1_perr, 1);
    cnt_clr   = 1'b1;
    req_valid = 32'h0000_0018;                               // clr beats increment
    tick();                                                  // T+4
    chk("clr_cnt0", u1_cnt, 0);
    cnt_clr = 1'b0;
    tick();                                                  // T+5
    chk("clr_cnt_resume", u1_cnt, 1);
    chk("perr_sticky2", u1_perr, 1);
    req_valid = '0;
    $display("protocol error: perr=%0d cnt=%0d", u1_perr, u1_cnt);

    // ---------------- reset mid-flight ----------------
    reset_dut();
    set_pattern();
    req_valid = bit_of(9);                                   // T
    #1;
    chk("mid_ready", u1_ready, bit_of(9));
    tick();                                                  // T+1
    rst_n = 1'b0;
    #1;
    chk("mid_async_rsp", u1_rsp_valid | u3_rsp_valid, 0);
    chk("mid_ready_rst", u1_ready, 0);
    chk("mid_rom_en_rst", u1_rom_en | u3_rom_en, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("mid_rsp_c%0d", c), u1_rsp_valid | u3_rsp_valid, 0);
    end
    chk("mid_data", (|u1_rsp_data) | (|u3_rsp_data), 0);
    req_valid = bit_of(20) | bit_of(3);
    rst_n     = 1'b1;
    #1;
    chk("mid_post_g3", u1_ready, bit_of(3));
    tick();
    req_valid = bit_of(20);
    #1;
    chk("mid_post_g20", u1_ready, bit_of(20));
    tick();
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("mid_no9_c%0d", c), u3_rsp_valid[9], 0);
    end
    $display("reset mid-flight: no stale responses");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
